// File: rtl/noc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | noc_pkg : shared NoC types and constants (address fields, flit, FSM) |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package noc_pkg;

  localparam int DWIDTH  = 16;
  localparam int ADDR_W  = 6;
  localparam int GRP_MSB = 5;
  localparam int GRP_LSB = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DWIDTH-1:0] data;
  } flit_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    STALL   = 2'd2
  } ing_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO with occupancy count, full and empty   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_fire, rd_fire;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign wr_fire = wr_en_i && !full_o;
  assign rd_fire = rd_en_i && !empty_o;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/gpu_ingress_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpu_ingress_buffer : GPU->router ingress FIFO with registered output |
// | and stall timeout. Optional macro GPU_INGRESS_DEST_CHECK_EN drops    |
// | flits addressed to SELF_ADDR.                                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gpu_ingress_buffer #(
  parameter int                DWIDTH     = 16,
  parameter int                ADDR_W     = 6,
  parameter int                FIFO_DEPTH = 8,
  parameter int                HOLD_MAX   = 15,
  parameter logic [ADDR_W-1:0] SELF_ADDR  = 6'b010001
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DWIDTH-1:0]             gpu_data_i,
  input  logic                          gpu_valid_i,
  input  logic [ADDR_W-1:0]             gpu_dest_i,
  output logic                          gpu_ready_o,
  output logic [DWIDTH-1:0]             rtr_data_o,
  output logic                          rtr_valid_o,
  output logic [ADDR_W-1:0]             rtr_dest_addr_o,
  input  logic                          rtr_ready_i,
  output logic                          fifo_full_o,
  output logic                          fifo_empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          stall_timeout_o,
  output logic [7:0]                    drop_count_o
);

  import noc_pkg::*;

  localparam int         FW       = ADDR_W + DWIDTH;
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

`ifdef GPU_INGRESS_DEST_CHECK_EN
  localparam bit DEST_CHECK = 1'b1;
`else
  localparam bit DEST_CHECK = 1'b0;
`endif

  ing_state_e        state_q, state_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [7:0]        stall_cnt_q, stall_cnt_d;
  logic [7:0]        drop_q, drop_d;

  logic              in_fire, drop_hit, enq, pop;
  logic [FW-1:0]     head;

  assign gpu_ready_o = !fifo_full_o;
  assign in_fire     = gpu_valid_i && gpu_ready_o;
  assign drop_hit    = DEST_CHECK && in_fire && (gpu_dest_i == SELF_ADDR);
  assign enq         = in_fire && !drop_hit;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (enq),
    .wr_data_i ({gpu_dest_i, gpu_data_i}),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .count_o   (fifo_count_o),
    .full_o    (fifo_full_o),
    .empty_o   (fifo_empty_o)
  );

  // An accept reloads from the FIFO head in the same edge to keep 1 flit/cycle.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    dest_d      = dest_q;
    stall_cnt_d = stall_cnt_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_o) begin
          pop         = 1'b1;
          {dest_d, data_d} = head;
          stall_cnt_d = '0;
          state_d     = PRESENT;
        end
      end
      PRESENT, STALL: begin
        if (rtr_ready_i) begin
          stall_cnt_d = '0;
          if (!fifo_empty_o) begin
            pop     = 1'b1;
            {dest_d, data_d} = head;
            state_d = PRESENT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = STALL;
          if (stall_cnt_q != HOLD_LIM) stall_cnt_d = stall_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (drop_hit && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      data_q      <= '0;
      dest_q      <= '0;
      stall_cnt_q <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      dest_q      <= dest_d;
      stall_cnt_q <= stall_cnt_d;
      drop_q      <= drop_d;
    end
  end

  assign rtr_valid_o     = (state_q != IDLE);
  assign rtr_data_o      = data_q;
  assign rtr_dest_addr_o = dest_q;
  assign stall_timeout_o = (state_q == STALL) && (stall_cnt_q == HOLD_LIM);
  assign drop_count_o    = drop_q;

endmodule
`default_nettype wire
